// File: rtl/mem_arbiter_pkg.sv
// Shared types for the I-cache / D-cache main-memory arbiter.
// The captured-request struct is sized to the package widths; the top slices it down to its parameters.
package mem_arbiter_pkg;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_LINE_W = 64;

  typedef enum logic {
    ICACHE = 1'b0,
    DCACHE = 1'b1
  } owner_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  typedef struct packed {
    logic                  we;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_LINE_W-1:0] wdata;
  } mem_req_t;

  // Round-robin tie break: whoever did not win last time goes first.
  function automatic owner_e rr_pick(input logic req_ic, input logic req_dc, input owner_e last);
    owner_e pick;
    pick = DCACHE;
    if (req_ic && req_dc) pick = (last == ICACHE) ? DCACHE : ICACHE;
    else if (req_ic)      pick = ICACHE;
    return pick;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_arbiter2.sv
// Two-way round-robin picker: combinational grant, registered last-grant pointer.
// The pointer resets to ICACHE so the D-cache wins the first tie.
module rr_arbiter2
  import mem_arbiter_pkg::*;
(
  input  logic   clock,
  input  logic   reset,
  input  logic   req_ic,
  input  logic   req_dc,
  input  logic   update,
  output logic   grant_valid,
  output owner_e grant
);

  owner_e last;

  always_comb begin
    grant_valid = req_ic | req_dc;
    grant       = rr_pick(req_ic, req_dc, last);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      last <= ICACHE;
    end else if (update && grant_valid) begin
      last <= grant;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one main-memory port between I-cache refills and D-cache reads/write-backs,
// one transaction at a time, with branch-redirect squash of in-flight instruction fetches.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = MEM_ADDR_W,
  parameter int LINE_WIDTH = MEM_LINE_W
) (
  input  logic                  clock,
  input  logic                  reset,

  input  logic                  ic_req_valid,
  input  logic [ADDR_WIDTH-1:0] ic_req_addr,
  output logic                  ic_req_ready,
  input  logic                  ic_cancel,
  output logic                  ic_resp_valid,
  output logic [LINE_WIDTH-1:0] ic_resp_data,

  input  logic                  dc_req_valid,
  input  logic                  dc_req_we,
  input  logic [ADDR_WIDTH-1:0] dc_req_addr,
  input  logic [LINE_WIDTH-1:0] dc_req_wdata,
  output logic                  dc_req_ready,
  output logic                  dc_resp_valid,
  output logic [LINE_WIDTH-1:0] dc_resp_data,

  output logic                  mem_req_valid,
  output logic                  mem_req_we,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic [LINE_WIDTH-1:0] mem_req_wdata,
  input  logic                  mem_req_ready,
  input  logic                  mem_resp_valid,
  input  logic [LINE_WIDTH-1:0] mem_resp_data,

  output logic                  busy
);

  state_e   state;
  owner_e   owner;
  mem_req_t cap_req;
  logic     squash;

  logic     req_ic;
  logic     grant_valid;
  owner_e   grant;
  logic     arb_update;
  logic     ic_kill;

  // A cancelled fetch is never a candidate, even in the cycle it is raised.
  assign req_ic     = ic_req_valid & ~ic_cancel;
  assign arb_update = reset & (state == IDLE);

  rr_arbiter2 u_rr (
    .clock       (clock),
    .reset       (reset),
    .req_ic      (req_ic),
    .req_dc      (dc_req_valid),
    .update      (arb_update),
    .grant_valid (grant_valid),
    .grant       (grant)
  );

  always_comb begin
    ic_req_ready = arb_update & grant_valid & (grant == ICACHE);
    dc_req_ready = arb_update & grant_valid & (grant == DCACHE);
  end

  assign mem_req_valid = (state == ISSUE);
  assign mem_req_we    = cap_req.we;
  assign mem_req_addr  = cap_req.addr[ADDR_WIDTH-1:0];
  assign mem_req_wdata = cap_req.wdata[LINE_WIDTH-1:0];
  assign busy          = (state != IDLE);

  // Squash also covers a cancel arriving in the same cycle as the memory response.
  assign ic_kill = squash | ic_cancel;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state         <= IDLE;
      owner         <= ICACHE;
      cap_req       <= '0;
      squash        <= 1'b0;
      ic_resp_valid <= 1'b0;
      ic_resp_data  <= '0;
      dc_resp_valid <= 1'b0;
      dc_resp_data  <= '0;
    end else begin
      ic_resp_valid <= 1'b0;
      dc_resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          squash <= 1'b0;
          if (grant_valid) begin
            owner <= grant;
            if (grant == DCACHE) begin
              cap_req.we    <= dc_req_we;
              cap_req.addr  <= MEM_ADDR_W'(dc_req_addr);
              cap_req.wdata <= MEM_LINE_W'(dc_req_wdata);
            end else begin
              cap_req.we    <= 1'b0;
              cap_req.addr  <= MEM_ADDR_W'(ic_req_addr);
              cap_req.wdata <= '0;
            end
            state <= ISSUE;
          end
        end

        ISSUE: begin
          if (ic_cancel && owner == ICACHE) squash <= 1'b1;
          if (mem_req_ready) begin
            if (cap_req.we) begin
              dc_resp_valid <= 1'b1;
              dc_resp_data  <= '0;
              squash        <= 1'b0;
              state         <= IDLE;
            end else begin
              state <= WAIT;
            end
          end
        end

        WAIT: begin
          if (ic_cancel && owner == ICACHE) squash <= 1'b1;
          if (mem_resp_valid) begin
            if (owner == ICACHE) begin
              if (!ic_kill) begin
                ic_resp_valid <= 1'b1;
                ic_resp_data  <= mem_resp_data;
              end
            end else begin
              dc_resp_valid <= 1'b1;
              dc_resp_data  <= mem_resp_data;
            end
            squash <= 1'b0;
            state  <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single main-memory port between the I-cache refill path (read-only line fetches feeding the fetch stage) and the D-cache (line reads and write-backs).
- Round-robin grant, one outstanding memory transaction at a time.
- Routes each response back to its owner.
- Lets the front end cancel an in-flight instruction fetch on a branch redirect.

Parameters:
- ADDR_WIDTH, 32, byte address width on all ports.
- LINE_WIDTH, 64, data width of one memory transfer (one fetch pack / cache line).

Ports:
- clock  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-low; reset==0 at posedge resets the block.
- ic_req_valid  in  1  I-cache read request.
- ic_req_addr  in  ADDR_WIDTH  I-cache line address.
- ic_req_ready  out  1  I-cache request accepted this cycle.
- ic_cancel  in  1  squash any pending I-cache request/response (branch redirect).
- ic_resp_valid  out  1  one-cycle pulse with returned line.
- ic_resp_data  out  LINE_WIDTH  returned line.
- dc_req_valid  in  1  D-cache request.
- dc_req_we  in  1  1 = write, 0 = read.
- dc_req_addr  in  ADDR_WIDTH  D-cache line address.
- dc_req_wdata  in  LINE_WIDTH  write data.
- dc_req_ready  out  1  D-cache request accepted this cycle.
- dc_resp_valid  out  1  one-cycle pulse: read data or write acknowledge.
- dc_resp_data  out  LINE_WIDTH  read data; 0 for write ack.
- mem_req_valid  out  1  request to memory.
- mem_req_we  out  1  write enable to memory.
- mem_req_addr  out  ADDR_WIDTH  memory address.
- mem_req_wdata  out  LINE_WIDTH  memory write data.
- mem_req_ready  in  1  memory accepts request.
- mem_resp_valid  in  1  memory read data valid.
- mem_resp_data  in  LINE_WIDTH  memory read data.
- busy  out  1  state != IDLE.

Behaviour:
- States: IDLE, ISSUE, WAIT.
- Reset (reset==0):
  - State IDLE; all outputs 0.
  - Captured request registers 0; squash flag 0.
  - rr_last = ICACHE, so D-cache wins the first tie.
  - Reset mid-transaction abandons it. A later mem_resp_valid is ignored because the block is in IDLE.
- IDLE:
  - Requesters are ic_req_valid && !ic_cancel, and dc_req_valid.
  - One requester: it wins. Both: the one that is not rr_last wins.
  - Winner's *_req_ready is asserted combinationally in that cycle. Owner, we, addr and wdata are captured; rr_last is set to the winner; next state ISSUE.
  - I-cache requests always have we = 0.
  - No requester: stay IDLE, all readies 0.
- ISSUE:
  - mem_req_valid = 1, driven from the captured registers and stable until accepted.
  - On mem_req_ready, a write goes to IDLE and dc_resp_valid pulses in the next cycle with data 0. A read goes to WAIT.
- WAIT:
  - mem_req_valid = 0.
  - On mem_resp_valid, data is registered and the owner's *_resp_valid pulses for exactly one cycle in the next cycle. The state returns to IDLE at the same edge.
- Latency:
  - Grant at cycle T gives mem_req_valid from T+1.
  - Memory response at cycle R gives resp_valid at R+1, and a new grant is possible at R+1.
  - Minimum idle-to-idle time for a read is 3 cycles with zero-wait memory.
- ic_cancel:
  - Asserted in any cycle while the owner is ICACHE in ISSUE or WAIT (including the cycle mem_resp_valid arrives), it sets the squash flag.
  - The transaction still completes on the memory side, so memory is never left mid-handshake. ic_resp_valid is suppressed.
  - The squash flag clears on return to IDLE.
  - ic_cancel has no effect on D-cache transactions.
- mem_resp_valid outside WAIT: ignored.
- Readies are 0 in ISSUE and WAIT. Requesters hold valid and fields until their ready is seen.
- ic_resp_data and dc_resp_data keep their last value when not valid. Only the valid bits are checked.

Decomposition:
- Shared package:
  - typedef enum for owner {ICACHE, DCACHE}.
  - typedef enum for state {IDLE, ISSUE, WAIT}.
  - mem_req_t struct {we, addr, wdata} for the captured request.
- Sub-module rr_arbiter2: 2-way round-robin pick with last-grant register and update enable. Combinational grant, sequential pointer.

Test Plan:
- Tie after reset:
  - Stimulus: ic_req_valid=1 addr 0x100 and dc_req_valid=1 read addr 0x200 in the same cycle.
  - Response: dc granted first (mem_req_addr=0x200). After its response, ic is granted (0x100).
- Single I-cache read:
  - Stimulus: memory responds 2 cycles after accept with data 0xDEADBEEF_00000001.
  - Response: ic_resp_valid high exactly one cycle, at R+1, with that data. busy returns to 0 at that same cycle.
- D-cache write:
  - Stimulus: dc write addr 0x40 wdata 0x1234; mem_req_ready held low 3 cycles, then high.
  - Response: mem_req_valid/we/addr/wdata stable for all 4 cycles; dc_resp_valid pulses the next cycle; ic never sees a response.
- Cancel during WAIT:
  - Stimulus: I-cache read at 0x80, ic_cancel pulsed in WAIT.
  - Response: memory response consumed, ic_resp_valid stays 0, the next dc request is granted on the following cycle.
- Cancel coincident with request:
  - Stimulus: ic_req_valid=1 and ic_cancel=1 in IDLE, dc idle.
  - Response: ic_req_ready=0, state stays IDLE.
- Reset mid-WAIT:
  - Stimulus: reset=0 for one cycle while in WAIT, then a stray mem_resp_valid.
  - Response: all outputs 0, no resp_valid, busy=0; the next tie is granted to dc.
